call_control: RTL

CALL_CONTROL -- requirements
Module: call_control

---
 rtl/call_pkg.sv | 38 +++
 rtl/call_control_if.sv | 29 ++
 rtl/dial_buffer.sv | 47 ++++
 rtl/call_control.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/call_pkg.sv
// Shared encodings for the handset call-control FSM: states, outbound commands,
// inbound application codes, and menu-item wrap helpers.
package call_pkg;

    localparam logic [2:0] ST_INIT     = 3'd0;
    localparam logic [2:0] ST_IDLE     = 3'd1;
    localparam logic [2:0] ST_MENU     = 3'd2;
    localparam logic [2:0] ST_DIAL     = 3'd3;
    localparam logic [2:0] ST_OUTGOING = 3'd4;
    localparam logic [2:0] ST_INCOMING = 3'd5;
    localparam logic [2:0] ST_BUSY     = 3'd6;
    localparam logic [2:0] ST_ENDING   = 3'd7;

    localparam logic [2:0] CMD_NONE    = 3'd0;
    localparam logic [2:0] CMD_DIAL    = 3'd1;
    localparam logic [2:0] CMD_ACCEPT  = 3'd2;
    localparam logic [2:0] CMD_REJECT  = 3'd3;
    localparam logic [2:0] CMD_HANGUP  = 3'd4;
    localparam logic [2:0] CMD_VMAIL   = 3'd5;

    localparam logic [2:0] INC_NONE    = 3'd0;
    localparam logic [2:0] INC_CONN    = 3'd1;
    localparam logic [2:0] INC_RREJ    = 3'd2;
    localparam logic [2:0] INC_RING    = 3'd5;
    localparam logic [2:0] INC_END     = 3'd6;

    // n is the item count of the list being scrolled (2..16)
    function automatic logic [3:0] item_next(input logic [3:0] cur, input logic [4:0] n);
        return ({1'b0, cur} >= (n - 5'd1)) ? 4'd0 : cur + 4'd1;
    endfunction

    function automatic logic [3:0] item_prev(input logic [3:0] cur, input logic [4:0] n);
        logic [4:0] w_last;
        w_last = n - 5'd1;
        return (cur == 4'd0) ? w_last[3:0] : cur - 4'd1;
    endfunction

endpackage

// File: rtl/call_control_if.sv
// Button/digit/application-layer bundle between the UI front end and call_control.
interface call_control_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    init;
    logic                    enter;
    logic                    up;
    logic                    down;
    logic                    left;
    logic                    right;
    logic                    digit_valid;
    logic [3:0]              digit;
    logic [2:0]              inc_command;
    logic [2:0]              command;
    logic [2:0]              current_state;
    logic [3:0]              current_menu_item;
    logic [4*NUM_DIGITS-1:0] phn_num;
    logic [4:0]              digit_count;

    modport master (
        output init, enter, up, down, left, right, digit_valid, digit, inc_command,
        input  command, current_state, current_menu_item, phn_num, digit_count
    );

    modport slave (
        input  init, enter, up, down, left, right, digit_valid, digit, inc_command,
        output command, current_state, current_menu_item, phn_num, digit_count
    );
endinterface

// File: rtl/dial_buffer.sv
// BCD dial buffer: newest digit in the low nibble, shift-in until full,
// backspace drops the newest digit, clear has priority over everything.
module dial_buffer #(
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_clr,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic [3:0]              i_digit,
    output logic [4*NUM_DIGITS-1:0] o_num,
    output logic [4:0]              o_count
);
    localparam logic [4:0] MAX_CNT = 5'(NUM_DIGITS);

    logic [4*NUM_DIGITS-1:0] r_num;
    logic [4:0]              r_cnt;
    logic [4*NUM_DIGITS-1:0] w_shift;

    generate
        if (NUM_DIGITS == 1) begin : g_one
            assign w_shift = i_digit;
        end else begin : g_many
            assign w_shift = {r_num[4*NUM_DIGITS-5:0], i_digit};
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_num <= '0;
            r_cnt <= 5'd0;
        end else if (i_clr) begin
            r_num <= '0;
            r_cnt <= 5'd0;
        end else if (i_push && (r_cnt < MAX_CNT)) begin
            r_num <= w_shift;
            r_cnt <= r_cnt + 5'd1;
        end else if (i_pop && (r_cnt != 5'd0)) begin
            r_num <= r_num >> 4;
            r_cnt <= r_cnt - 5'd1;
        end
    end

    assign o_num   = r_num;
    assign o_count = r_cnt;
endmodule

// File: rtl/call_control.sv
// Handset call-control FSM: menu navigation, dialing, ring/answer/hang-up
// sequencing with a per-state ring timeout and one-cycle command pulses.
module call_control
    import call_pkg::*;
#(
    parameter int          NUM_DIGITS   = 4,
    parameter logic [31:0] RING_TIMEOUT = 32'd1_000_000,
    parameter int          MENU_ITEMS   = 4
) (
    input logic           clk,
    input logic           reset,
    call_control_if.slave bus
);
    localparam logic [4:0] MENU_N = 5'(MENU_ITEMS);

    logic [2:0]  r_state;
    logic [3:0]  r_item;
    logic [2:0]  r_cmd;
    logic [31:0] r_tmo;

    logic [2:0]  w_nstate;
    logic [3:0]  w_nitem;
    logic [2:0]  w_ncmd;
    logic        w_clr, w_push, w_pop;
    logic        w_enter, w_left, w_right, w_up, w_down;
    logic        w_timed, w_expire, w_digit_ok, w_has_digits;
    logic [4*NUM_DIGITS-1:0] w_num;
    logic [4:0]  w_count;

    // one button per cycle: enter > left > right > up > down
    always_comb begin
        w_enter = bus.enter;
        w_left  = bus.left  & ~bus.enter;
        w_right = bus.right & ~bus.enter & ~bus.left;
        w_up    = bus.up    & ~bus.enter & ~bus.left & ~bus.right;
        w_down  = bus.down  & ~bus.enter & ~bus.left & ~bus.right & ~bus.up;
    end

    assign w_timed      = (r_state == ST_OUTGOING) || (r_state == ST_INCOMING) ||
                          (r_state == ST_ENDING);
    // >= keeps expiry live if a button action in the expiry cycle masked it
    assign w_expire     = w_timed && (r_tmo >= (RING_TIMEOUT - 32'd1));
    assign w_digit_ok   = bus.digit_valid && (bus.digit <= 4'd9);
    assign w_has_digits = (w_count != 5'd0);

    always_comb begin
        w_nstate = r_state;
        w_nitem  = r_item;
        w_ncmd   = CMD_NONE;
        w_clr    = 1'b0;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (bus.init || w_enter) w_nstate = ST_IDLE;
            end
            ST_IDLE: begin
                if (bus.inc_command == INC_RING) w_nstate = ST_INCOMING;
                else if (w_right)                w_nstate = ST_MENU;
            end
            ST_MENU: begin
                if (bus.inc_command == INC_RING) begin
                    w_nstate = ST_INCOMING;
                    w_clr    = 1'b1;
                end else if (w_enter) begin
                    if (r_item == 4'd0) begin
                        w_nstate = ST_DIAL;
                        w_clr    = 1'b1;
                    end else if (r_item == 4'd1) begin
                        w_ncmd   = CMD_VMAIL;
                    end
                end else if (w_left) begin
                    w_nstate = ST_IDLE;
                end else if (w_up) begin
                    w_nitem  = item_prev(r_item, MENU_N);
                end else if (w_down) begin
                    w_nitem  = item_next(r_item, MENU_N);
                end
            end
            ST_DIAL: begin
                if (bus.inc_command == INC_RING) begin
                    w_nstate = ST_INCOMING;
                    w_clr    = 1'b1;
                end else if (w_enter) begin
                    if (w_has_digits) begin
                        w_nstate = ST_OUTGOING;
                        w_ncmd   = CMD_DIAL;
                    end
                end else if (w_left) begin
                    if (w_has_digits) w_pop    = 1'b1;
                    else              w_nstate = ST_MENU;
                end else if (w_digit_ok) begin
                    w_push = 1'b1;
                end
            end
            ST_OUTGOING: begin
                if (bus.inc_command == INC_CONN) begin
                    w_nstate = ST_BUSY;
                end else if ((bus.inc_command == INC_RREJ) || (bus.inc_command == INC_END)) begin
                    w_nstate = ST_IDLE;
                end else if (w_expire) begin
                    w_nstate = ST_IDLE;
                    w_ncmd   = CMD_HANGUP;
                end
            end
            ST_INCOMING: begin
                if (bus.inc_command == INC_END) begin
                    w_nstate = ST_IDLE;
                end else if (w_enter && (r_item == 4'd1)) begin
                    w_nstate = ST_BUSY;
                    w_ncmd   = CMD_ACCEPT;
                end else if (w_enter && (r_item == 4'd2)) begin
                    w_nstate = ST_IDLE;
                    w_ncmd   = CMD_REJECT;
                end else if (w_up) begin
                    w_nitem  = item_prev(r_item, 5'd3);
                end else if (w_down) begin
                    w_nitem  = item_next(r_item, 5'd3);
                end else if (w_expire) begin
                    w_nstate = ST_IDLE;
                    w_ncmd   = CMD_REJECT;
                end
            end
            ST_BUSY: begin
                // remote hang-up beats a local end-call in the same cycle
                if (bus.inc_command == INC_END) begin
                    w_nstate = ST_IDLE;
                end else if (w_enter && (r_item == 4'd1)) begin
                    w_nstate = ST_ENDING;
                    w_ncmd   = CMD_HANGUP;
                end else if (w_up) begin
                    w_nitem  = item_prev(r_item, 5'd2);
                end else if (w_down) begin
                    w_nitem  = item_next(r_item, 5'd2);
                end
            end
            ST_ENDING: begin
                if ((bus.inc_command == INC_END) || w_expire) w_nstate = ST_IDLE;
            end
            default: w_nstate = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_INIT;
            r_item  <= 4'd0;
            r_cmd   <= CMD_NONE;
            r_tmo   <= 32'd0;
        end else begin
            r_state <= w_nstate;
            r_cmd   <= w_ncmd;
            if (w_nstate != r_state) begin
                r_item <= 4'd0;
                r_tmo  <= 32'd0;
            end else begin
                r_item <= w_nitem;
                if (w_timed) r_tmo <= r_tmo + 32'd1;
            end
        end
    end

    dial_buffer #(.NUM_DIGITS(NUM_DIGITS)) u_dial (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_clr),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_digit (bus.digit),
        .o_num   (w_num),
        .o_count (w_count)
    );

    assign bus.command           = r_cmd;
    assign bus.current_state     = r_state;
    assign bus.current_menu_item = r_item;
    assign bus.phn_num           = w_num;
    assign bus.digit_count       = w_count;
endmodule
